// File: rtl/m68k_bus_pkg.sv
// rtl/m68k_bus_pkg.sv - shared types and constants for the 68000-to-memory bridge
package m68k_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK,
    ST_ERR
  } bridge_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int WINDOW_ADDR_W          = 18;

endpackage

// File: rtl/m68k_mem_bridge_if.sv
// rtl/m68k_mem_bridge_if.sv - word-wide synchronous memory port between bridge and memory
interface m68k_mem_bridge_if;
  import m68k_bus_pkg::*;

  logic [WINDOW_ADDR_W-1:0] mem_addr;
  logic [15:0]              mem_data_write;
  logic [15:0]              mem_data_read;
  logic                     mem_uds;
  logic                     mem_lds;
  logic                     mem_rw;
  logic                     mem_ack;

  modport master (
    output mem_addr, mem_data_write, mem_uds, mem_lds, mem_rw,
    input  mem_data_read, mem_ack
  );

  modport slave (
    input  mem_addr, mem_data_write, mem_uds, mem_lds, mem_rw,
    output mem_data_read, mem_ack
  );

endinterface

// File: rtl/bus_sync.sv
// rtl/bus_sync.sv - two-flop synchronizer for an active-low CPU strobe, resets to idle (1)
module bus_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/m68k_mem_bridge.sv
// rtl/m68k_mem_bridge.sv - 68000 async bus to synchronous word memory bridge
// M68K_BUS_TIMEOUT_EN enables the mem_ack watchdog that raises BERR.
module m68k_mem_bridge
  import m68k_bus_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR      = 24'h000000,
  parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:1] cpu_addr,
  input  logic        cpu_as_n,
  input  logic        cpu_uds_n,
  input  logic        cpu_lds_n,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  output logic        cpu_data_oe,
  output logic        cpu_dtack_n,
  output logic        cpu_berr_n,
  m68k_mem_bridge_if.master mem
);

  logic as_s, uds_s, lds_s, rw_s;

  bus_sync u_sync_as  (.clk(clk), .reset_n(reset_n), .d(cpu_as_n),  .q(as_s));
  bus_sync u_sync_uds (.clk(clk), .reset_n(reset_n), .d(cpu_uds_n), .q(uds_s));
  bus_sync u_sync_lds (.clk(clk), .reset_n(reset_n), .d(cpu_lds_n), .q(lds_s));
  bus_sync u_sync_rw  (.clk(clk), .reset_n(reset_n), .d(cpu_rw),    .q(rw_s));

  bridge_state_t            state;
  logic [WINDOW_ADDR_W-1:0] addr_q;
  logic [15:0]              wdata_q;
  logic                     uds_q, lds_q, rw_q;
  logic                     in_window;

  assign in_window = (cpu_addr[23:18] == BASE_ADDR[23:18]);

`ifdef M68K_BUS_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       berr_q;
  assign cpu_berr_n = berr_q;
`else
  assign cpu_berr_n = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      uds_q        <= 1'b0;
      lds_q        <= 1'b0;
      rw_q         <= 1'b1;
      cpu_data_out <= '0;
      cpu_data_oe  <= 1'b0;
      cpu_dtack_n  <= 1'b1;
`ifdef M68K_BUS_TIMEOUT_EN
      cnt_q        <= '0;
      berr_q       <= 1'b1;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!as_s && (!uds_s || !lds_s) && in_window) begin
            addr_q  <= {1'b0, cpu_addr[17:1]};
            wdata_q <= cpu_data_in;
            rw_q    <= rw_s;
            uds_q   <= ~uds_s;
            lds_q   <= ~lds_s;
`ifdef M68K_BUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (as_s) begin
            uds_q <= 1'b0;
            lds_q <= 1'b0;
            state <= ST_IDLE;
          end else if (mem.mem_ack) begin
            // Unselected lanes carry garbage from memory; zero them.
            if (rw_q)
              cpu_data_out <= {uds_q ? mem.mem_data_read[15:8] : 8'h00,
                               lds_q ? mem.mem_data_read[7:0]  : 8'h00};
            cpu_data_oe <= rw_q;
            cpu_dtack_n <= 1'b0;
            uds_q       <= 1'b0;
            lds_q       <= 1'b0;
            state       <= ST_ACK;
          end
`ifdef M68K_BUS_TIMEOUT_EN
          else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
            berr_q <= 1'b0;
            uds_q  <= 1'b0;
            lds_q  <= 1'b0;
            state  <= ST_ERR;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        ST_ACK: begin
          if (as_s) begin
            cpu_dtack_n <= 1'b1;
            cpu_data_oe <= 1'b0;
            state       <= ST_IDLE;
          end
        end
`ifdef M68K_BUS_TIMEOUT_EN
        ST_ERR: begin
          if (as_s) begin
            berr_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_addr       = addr_q;
  assign mem.mem_data_write = wdata_q;
  assign mem.mem_uds        = uds_q;
  assign mem.mem_lds        = lds_q;
  assign mem.mem_rw         = rw_q;

endmodule

// File: tb/tb_m68k_mem_bridge.sv
// tb/tb_m68k_mem_bridge.sv - directed self-checking bench for m68k_mem_bridge
module tb_m68k_mem_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:1] cpu_addr;
  logic        cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw;
  logic [15:0] cpu_data_in;
  logic [15:0] cpu_data_out;
  logic        cpu_data_oe, cpu_dtack_n, cpu_berr_n;

  m68k_mem_bridge_if mif ();

  m68k_mem_bridge dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_addr    (cpu_addr),
    .cpu_as_n    (cpu_as_n),
    .cpu_uds_n   (cpu_uds_n),
    .cpu_lds_n   (cpu_lds_n),
    .cpu_rw      (cpu_rw),
    .cpu_data_in (cpu_data_in),
    .cpu_data_out(cpu_data_out),
    .cpu_data_oe (cpu_data_oe),
    .cpu_dtack_n (cpu_dtack_n),
    .cpu_berr_n  (cpu_berr_n),
    .mem         (mif.master)
  );

  always #5 clk = ~clk;

  // Memory model: registered one-cycle ack pulse after strobes rise, write on rise.
  logic [15:0] mem_arr [0:4095];
  logic        ack_en;
  logic        busy;
  int          strobe_rises;
  int          uds_cycles;
  logic [15:0] rd_word;

  always @(posedge clk) begin
    if (!reset_n) begin
      busy              <= 1'b0;
      mif.mem_ack       <= 1'b0;
      strobe_rises      <= 0;
      uds_cycles        <= 0;
      mem_arr[12'h080]  <= 16'hBEEF;
      mem_arr[12'h100]  <= 16'h1122;
      mem_arr[12'h180]  <= 16'h1234;
    end else begin
      busy <= mif.mem_uds | mif.mem_lds;
      if (mif.mem_uds)
        uds_cycles <= uds_cycles + 1;
      if ((mif.mem_uds | mif.mem_lds) && !busy) begin
        strobe_rises <= strobe_rises + 1;
        mif.mem_ack  <= ack_en;
        if (!mif.mem_rw) begin
          if (mif.mem_uds) mem_arr[mif.mem_addr[11:0]][15:8] <= mif.mem_data_write[15:8];
          if (mif.mem_lds) mem_arr[mif.mem_addr[11:0]][7:0]  <= mif.mem_data_write[7:0];
        end
      end else begin
        mif.mem_ack <= 1'b0;
      end
    end
  end

  assign rd_word           = mem_arr[mif.mem_addr[11:0]];
  assign mif.mem_data_read = {mif.mem_uds ? rd_word[15:8] : 8'hA5,
                              mif.mem_lds ? rd_word[7:0]  : 8'hA5};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_start(input logic [23:0] a, input logic rw, input logic u, input logic l,
                           input logic [15:0] wd);
    @(negedge clk);
    cpu_addr    = a[23:1];
    cpu_rw      = rw;
    cpu_data_in = wd;
    cpu_as_n    = 1'b0;
    cpu_uds_n   = ~u;
    cpu_lds_n   = ~l;
  endtask

  task automatic wait_dtack(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (cpu_dtack_n && n < 50);
  endtask

  task automatic cpu_end(output int n);
    cpu_as_n  = 1'b1;
    cpu_uds_n = 1'b1;
    cpu_lds_n = 1'b1;
    n = 0;
    while ((!cpu_dtack_n || !cpu_berr_n) && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  int n, r0, u0;

  initial begin
    reset_n = 1'b0; ack_en = 1'b1;
    cpu_addr = '0; cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    cpu_rw = 1'b1; cpu_data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dtack", cpu_dtack_n, 1);
    check("rst_berr", cpu_berr_n, 1);
    check("rst_oe", cpu_data_oe, 0);
    check("rst_dout", cpu_data_out, 0);
    check("rst_strobes", {mif.mem_uds, mif.mem_lds}, 0);
    check("rst_rw", mif.mem_rw, 1);
    check("rst_addr", mif.mem_addr, 0);
    check("rst_wdata", mif.mem_data_write, 0);
    reset_n = 1'b1;

    // Word read at 0x000100 -> word 0x80
    cpu_start(24'h000100, 1'b1, 1'b1, 1'b1, 16'h0000);
    wait_dtack(n);
    check("rd_latency", n, 5);
    check("rd_data", cpu_data_out, 16'hBEEF);
    check("rd_oe", cpu_data_oe, 1);
    check("rd_addr", mif.mem_addr, 18'h00080);
    check("rd_strobes_dropped", {mif.mem_uds, mif.mem_lds}, 0);
    cpu_end(n);
    check("rd_release", (n >= 2 && n <= 3), 1);
    check("rd_oe_release", cpu_data_oe, 0);

    // Byte write 0x5A, LDS only, to 0x000201 -> word 0x100 low byte
    r0 = strobe_rises; u0 = uds_cycles;
    cpu_start(24'h000201, 1'b0, 1'b0, 1'b1, 16'h005A);
    wait_dtack(n);
    check("wr_latency", n, 5);
    check("wr_oe", cpu_data_oe, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wr_dtack_hold", cpu_dtack_n, 0);
    cpu_end(n);
    check("wr_release", cpu_dtack_n, 1);
    check("wr_one_strobe", strobe_rises - r0, 1);
    check("wr_no_uds", uds_cycles - u0, 0);
    check("wr_mem", mem_arr[12'h100], 16'h115A);

    // UDS-only read of word 0x180 holding 0x1234
    cpu_start(24'h000300, 1'b1, 1'b1, 1'b0, 16'h0000);
    wait_dtack(n);
    check("uds_rd_latency", n, 5);
    check("uds_rd_data", cpu_data_out, 16'h1200);
    cpu_end(n);

    // Out-of-window access
    r0 = strobe_rises;
    cpu_start(24'h040000, 1'b1, 1'b1, 1'b1, 16'h0000);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("oow_dtack", cpu_dtack_n, 1);
    check("oow_berr", cpu_berr_n, 1);
    check("oow_no_strobe", strobe_rises - r0, 0);
    cpu_end(n);

    // Memory never acknowledges
    ack_en = 1'b0;
    cpu_start(24'h000100, 1'b1, 1'b1, 1'b1, 16'h0000);
`ifdef M68K_BUS_TIMEOUT_EN
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (cpu_berr_n && n < 150);
    check("to_berr", cpu_berr_n, 0);
    check("to_latency", n, 67);
    check("to_dtack", cpu_dtack_n, 1);
    check("to_strobes", {mif.mem_uds, mif.mem_lds}, 0);
    cpu_end(n);
    check("to_berr_release", cpu_berr_n, 1);
`else
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("to_no_berr", cpu_berr_n, 1);
    check("to_no_dtack", cpu_dtack_n, 1);
    check("to_strobes_held", {mif.mem_uds, mif.mem_lds}, 2'b11);
    cpu_end(n);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_strobes", {mif.mem_uds, mif.mem_lds}, 0);
    check("abort_dtack", cpu_dtack_n, 1);
`endif

    // Reset while in REQ
    cpu_start(24'h000100, 1'b1, 1'b1, 1'b1, 16'h0000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_rst_req", mif.mem_uds, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_strobes", {mif.mem_uds, mif.mem_lds}, 0);
    check("mid_rst_rw", mif.mem_rw, 1);
    check("mid_rst_addr", mif.mem_addr, 0);
    check("mid_rst_wdata", mif.mem_data_write, 0);
    check("mid_rst_dtack", cpu_dtack_n, 1);
    check("mid_rst_dout", cpu_data_out, 0);
    cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cpu_start(24'h000300, 1'b1, 1'b1, 1'b1, 16'h0000);
    wait_dtack(n);
    check("post_rst_latency", n, 5);
    check("post_rst_data", cpu_data_out, 16'h1234);
    cpu_end(n);
    check("post_rst_release", cpu_dtack_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
